// File: rtl/adc_frame_packer.sv
// Per-channel ADC frame packer: captures a triggered frame of 14-bit samples into a 32-bit show-ahead FIFO.
// Optional feature macro: TRIG_TIMESTAMP_EN adds a free-running cycle counter and a timestamp word after each header.
//
// state   | meaning
// IDLE    | waiting for TRIGGER with EN; admits a frame only if it fits completely in the FIFO
// COLLECT | packing samples two per word until FRAME_LEN samples have arrived
module adc_frame_packer #(
  parameter int ADC_ID     = 0,
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        EN,
  input  logic        CLEAR,
  input  logic        TRIGGER,
  input  logic        ADC_VALID,
  input  logic [13:0] ADC_IN,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic        BUSY,
  output logic        LOST_ERROR,
  output logic [7:0]  LOST_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef TRIG_TIMESTAMP_EN
  localparam int NEED = FRAME_LEN / 2 + 2;
`else
  localparam int NEED = FRAME_LEN / 2 + 1;
`endif
  // Largest occupancy at which a whole frame (header included) still fits.
  localparam logic [CW-1:0] MAX_OCC  = CW'(FIFO_DEPTH - NEED);
  localparam logic [11:0]   LAST_IDX = 12'(FRAME_LEN - 1);
  localparam logic [2:0]    ID       = 3'(ADC_ID);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic [15:0]   frame_cnt;
  logic [13:0]   held;
  logic          odd_phase;
  logic [11:0]   remain;
  logic          push, pop, accept, drop;
  logic [31:0]   push_data;
  logic          lost_error;
  logic [7:0]    lost_cnt;

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_reg;
  logic        ts_pending;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      ts_cnt     <= '0;
      ts_reg     <= '0;
      ts_pending <= 1'b0;
    end else begin
      ts_cnt     <= ts_cnt + 32'd1;
      ts_pending <= accept;
      if (accept) ts_reg <= ts_cnt;
    end
  end
`endif

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (TRIGGER && EN) begin
          if (occ <= MAX_OCC) begin
            accept    = 1'b1;
            push      = 1'b1;
            push_data = {1'b1, ID, 12'h000, frame_cnt};
            state_nxt = COLLECT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      COLLECT: begin
`ifdef TRIG_TIMESTAMP_EN
        // First COLLECT cycle never carries an odd sample, so this write cannot collide.
        if (ts_pending) begin
          push      = 1'b1;
          push_data = ts_reg;
        end
`endif
        if (ADC_VALID) begin
          if (odd_phase) begin
            push      = 1'b1;
            push_data = {1'b0, ID, ADC_IN, held};
          end
          if (remain == 12'd0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      remain    <= '0;
      odd_phase <= 1'b0;
      held      <= '0;
    end else if (accept) begin
      remain    <= LAST_IDX;
      odd_phase <= 1'b0;
    end else if (state == COLLECT && ADC_VALID) begin
      remain    <= remain - 12'd1;
      odd_phase <= ~odd_phase;
      if (!odd_phase) held <= ADC_IN;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      frame_cnt  <= '0;
      lost_error <= 1'b0;
      lost_cnt   <= '0;
    end else if (CLEAR) begin
      frame_cnt  <= '0;
      lost_error <= 1'b0;
      lost_cnt   <= '0;
    end else begin
      if (accept) frame_cnt <= frame_cnt + 16'd1;
      if (drop) begin
        lost_error <= 1'b1;
        if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  assign pop = FIFO_READ && (occ != '0);

  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign FIFO_EMPTY = (occ == '0);
  assign FIFO_DATA  = FIFO_EMPTY ? 32'h0 : mem[rd_ptr];
  assign BUSY       = (state == COLLECT);
  assign LOST_ERROR = lost_error;
  assign LOST_CNT   = lost_cnt;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer (ADC_ID=2, FRAME_LEN=4, FIFO_DEPTH=8); honours TRIG_TIMESTAMP_EN.
module tb_adc_frame_packer;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N;
  logic        EN, CLEAR, TRIGGER, ADC_VALID, FIFO_READ;
  logic [13:0] ADC_IN;
  logic        FIFO_EMPTY, BUSY, LOST_ERROR;
  logic [31:0] FIFO_DATA;
  logic [7:0]  LOST_CNT;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        rd_en = 1'b0;
  logic [31:0] cyc = 0;

  adc_frame_packer #(.ADC_ID(2), .FRAME_LEN(4), .FIFO_DEPTH(8)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .EN(EN), .CLEAR(CLEAR),
    .TRIGGER(TRIGGER), .ADC_VALID(ADC_VALID), .ADC_IN(ADC_IN),
    .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .BUSY(BUSY), .LOST_ERROR(LOST_ERROR), .LOST_CNT(LOST_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Mirror of the free-running cycle counter: posedges seen since reset release.
  initial forever begin
    @(posedge BUS_CLK or negedge BUS_RST_N);
    if (!BUS_RST_N) cyc = 0;
    else            cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [15:0] cnt);
    return {1'b1, 3'd2, 12'h000, cnt};
  endfunction

  function automatic logic [31:0] dat(input logic [13:0] s_even, input logic [13:0] s_odd);
    return {1'b0, 3'd2, s_odd, s_even};
  endfunction

  task automatic push_frame(input logic [15:0] cnt, input logic [31:0] ts,
                            input logic [13:0] a, input logic [13:0] b,
                            input logic [13:0] c, input logic [13:0] d);
    exp_q.push_back(hdr(cnt));
`ifdef TRIG_TIMESTAMP_EN
    exp_q.push_back(ts);
`endif
    exp_q.push_back(dat(a, b));
    exp_q.push_back(dat(c, d));
  endtask

  // Monitor: pops the head word whenever the DUT presents one and reading is enabled.
  initial begin
    FIFO_READ = 1'b0;
    forever begin
      @(negedge BUS_CLK);
      FIFO_READ = 1'b0;
      if (rd_en && BUS_RST_N && !FIFO_EMPTY) begin
        if (exp_q.size() == 0) chk("unexpected_word", FIFO_DATA, 32'hDEAD_BEEF);
        else                   chk("fifo_word", FIFO_DATA, exp_q.pop_front());
        FIFO_READ = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge BUS_CLK);
    #1;
  endtask

  task automatic sample(input logic [13:0] v, input int gap);
    ADC_VALID = 1'b1;
    ADC_IN    = v;
    tick(1);
    ADC_VALID = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && FIFO_EMPTY) break;
      tick(1);
    end
    chk({name, "_empty"}, {31'b0, FIFO_EMPTY}, 32'd1);
    chk({name, "_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    BUS_RST_N = 1'b0; EN = 1'b0; CLEAR = 1'b0; TRIGGER = 1'b0;
    ADC_VALID = 1'b0; ADC_IN = '0;
    tick(3);
    chk("rst_empty", {31'b0, FIFO_EMPTY}, 32'd1);
    chk("rst_data", FIFO_DATA, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_lost_err", {31'b0, LOST_ERROR}, 32'd0);
    chk("rst_lost_cnt", {24'b0, LOST_CNT}, 32'd0);
    BUS_RST_N = 1'b1;
    tick(2);

    // Basic frame, contiguous samples.
    rd_en = 1'b1; EN = 1'b1; TRIGGER = 1'b1;
    push_frame(16'd0, cyc, 14'd1, 14'd2, 14'd3, 14'd4);
    tick(1);
    TRIGGER = 1'b0;
    chk("t1_busy_set", {31'b0, BUSY}, 32'd1);
    sample(14'd1, 0); sample(14'd2, 0); sample(14'd3, 0);
    chk("t1_busy_mid", {31'b0, BUSY}, 32'd1);
    sample(14'd4, 0);
    chk("t1_busy_clr", {31'b0, BUSY}, 32'd0);
    drain("t1");

    // Gapped ADC_VALID: one valid sample every third cycle.
    TRIGGER = 1'b1;
    push_frame(16'd1, cyc, 14'd1, 14'd2, 14'd3, 14'd4);
    tick(1);
    TRIGGER = 1'b0;
    tick(1);
    sample(14'd1, 2); sample(14'd2, 2); sample(14'd3, 2);
    chk("t2_busy_held", {31'b0, BUSY}, 32'd1);
    sample(14'd4, 0);
    chk("t2_busy_clr", {31'b0, BUSY}, 32'd0);
    drain("t2");

    // Fill without reading: two frames fit, the third trigger is dropped.
    rd_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      TRIGGER = 1'b1;
      push_frame(16'(2 + f), cyc, 14'(16 * f + 5), 14'(16 * f + 6), 14'(16 * f + 7), 14'(16 * f + 8));
      tick(1);
      TRIGGER = 1'b0;
      sample(14'(16 * f + 5), 0); sample(14'(16 * f + 6), 0);
      sample(14'(16 * f + 7), 0); sample(14'(16 * f + 8), 0);
    end
    TRIGGER = 1'b1;
    tick(1);
    TRIGGER = 1'b0;
    chk("t3_drop_busy", {31'b0, BUSY}, 32'd0);
    chk("t3_lost_err", {31'b0, LOST_ERROR}, 32'd1);
    chk("t3_lost_cnt", {24'b0, LOST_CNT}, 32'd1);
    chk("t3_not_empty", {31'b0, FIFO_EMPTY}, 32'd0);
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    chk("t3_clr_err", {31'b0, LOST_ERROR}, 32'd0);
    chk("t3_clr_cnt", {24'b0, LOST_CNT}, 32'd0);
    // Trigger with EN low while full: neither a frame nor a drop.
    EN = 1'b0; TRIGGER = 1'b1;
    tick(1);
    TRIGGER = 1'b0; EN = 1'b1;
    chk("t3_en0_busy", {31'b0, BUSY}, 32'd0);
    chk("t3_en0_cnt", {24'b0, LOST_CNT}, 32'd0);
    rd_en = 1'b1;
    drain("t3");

    // TRIGGER held for 20 cycles with continuous samples: frames every 5 cycles.
    base = cyc;
    for (int k = 0; k < 4; k++)
      push_frame(16'(k), base + 32'(5 * k), 14'(101 + 5 * k), 14'(102 + 5 * k),
                 14'(103 + 5 * k), 14'(104 + 5 * k));
    TRIGGER = 1'b1; ADC_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ADC_IN = 14'(100 + i);
      tick(1);
    end
    TRIGGER = 1'b0; ADC_VALID = 1'b0;
    chk("t4_busy_end", {31'b0, BUSY}, 32'd0);
    chk("t4_lost_cnt", {24'b0, LOST_CNT}, 32'd0);
    drain("t4");

    // Reset in the middle of a frame discards everything.
    rd_en = 1'b0; TRIGGER = 1'b1;
    tick(1);
    TRIGGER = 1'b0;
    sample(14'd1, 0); sample(14'd2, 0); sample(14'd3, 0);
    chk("t5_pre_busy", {31'b0, BUSY}, 32'd1);
    BUS_RST_N = 1'b0;
    #1;
    chk("t5_async_empty", {31'b0, FIFO_EMPTY}, 32'd1);
    chk("t5_async_busy", {31'b0, BUSY}, 32'd0);
    chk("t5_async_data", FIFO_DATA, 32'h0);
    tick(2);
    BUS_RST_N = 1'b1;
    tick(1);
    rd_en = 1'b1; TRIGGER = 1'b1;
    push_frame(16'd0, cyc, 14'h3FFF, 14'h0000, 14'h2AAA, 14'h1555);
    tick(1);
    TRIGGER = 1'b0;
    sample(14'h3FFF, 0); sample(14'h0000, 1); sample(14'h2AAA, 0); sample(14'h1555, 0);
    chk("t5_busy_clr", {31'b0, BUSY}, 32'd0);
    drain("t5");

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
